// File: rtl/agu_2d_if.sv
// agu_2d_if: bus between the matrix-op controller and the 2-D address
// generation unit.
//   clr_en, add_en   per-channel load / advance strobes (controller -> AGU)
//   cfg_*            packed per-channel configuration (controller -> AGU)
//   addr             packed per-channel registered address (AGU -> controller)
//   row_last, done   per-channel status (AGU -> controller)
// Channel i occupies slice [i*W +: W] of every packed bus.
interface agu_2d_if #(
   parameter int ADDR_WIDTH = 14,
   parameter int NUM_CH     = 4,
   parameter int CNT_WIDTH  = 10
);
   logic [NUM_CH-1:0]            clr_en;
   logic [NUM_CH-1:0]            add_en;
   logic [NUM_CH*ADDR_WIDTH-1:0] cfg_start;
   logic [NUM_CH*ADDR_WIDTH-1:0] cfg_stride_in;
   logic [NUM_CH*ADDR_WIDTH-1:0] cfg_stride_out;
   logic [NUM_CH*CNT_WIDTH-1:0]  cfg_len_in;
   logic [NUM_CH*CNT_WIDTH-1:0]  cfg_len_out;
   logic [NUM_CH*ADDR_WIDTH-1:0] addr;
   logic [NUM_CH-1:0]            row_last;
   logic [NUM_CH-1:0]            done;

   modport master (
      output clr_en, add_en, cfg_start, cfg_stride_in, cfg_stride_out,
             cfg_len_in, cfg_len_out,
      input  addr, row_last, done
   );

   modport slave (
      input  clr_en, add_en, cfg_start, cfg_stride_in, cfg_stride_out,
             cfg_len_in, cfg_len_out,
      output addr, row_last, done
   );
endinterface

// File: rtl/agu_2d.sv
// agu_2d: multi-channel 2-D address generation unit.
// Each channel walks an inner loop (stride_in, len_in+1 iterations) nested
// in an outer loop (stride_out applied to the row base, len_out+1 rows).
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   agu_2d_if.slave: clr_en/add_en strobes, cfg_* buses in,
//         addr/row_last/done out
// Build option: define AGU_WRAP_EN to make a finished pattern reload its
// start address and continue (done pulses one cycle); otherwise done is
// sticky and the channel freezes until the next clr_en.
module agu_2d #(
   parameter int ADDR_WIDTH = 14,
   parameter int NUM_CH     = 4,
   parameter int CNT_WIDTH  = 10
) (
   input logic     clk,
   input logic     rstn,
   agu_2d_if.slave bus
);

   logic [ADDR_WIDTH-1:0] addr_ch [NUM_CH];
   logic [NUM_CH-1:0]     row_last_ch;
   logic [NUM_CH-1:0]     done_ch;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [ADDR_WIDTH-1:0] addr_q, base_q, si_q, so_q;
      logic [CNT_WIDTH-1:0]  icnt_q, ocnt_q, li_q, lo_q;
      logic                  done_q;
      logic                  inner_end, outer_end, step;
`ifdef AGU_WRAP_EN
      logic [ADDR_WIDTH-1:0] start_q;
`endif

      assign inner_end = (icnt_q == li_q);
      assign outer_end = (ocnt_q == lo_q);

`ifdef AGU_WRAP_EN
      assign step           = bus.add_en[i];
      assign row_last_ch[i] = inner_end;
`else
      assign step           = bus.add_en[i] & ~done_q;
      assign row_last_ch[i] = inner_end & ~done_q;
`endif

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            addr_q <= '0;
            base_q <= '0;
            si_q   <= '0;
            so_q   <= '0;
            icnt_q <= '0;
            ocnt_q <= '0;
            li_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
`ifdef AGU_WRAP_EN
            start_q <= '0;
`endif
         end else if (bus.clr_en[i]) begin
            addr_q <= bus.cfg_start[i*ADDR_WIDTH +: ADDR_WIDTH];
            base_q <= bus.cfg_start[i*ADDR_WIDTH +: ADDR_WIDTH];
            si_q   <= bus.cfg_stride_in[i*ADDR_WIDTH +: ADDR_WIDTH];
            so_q   <= bus.cfg_stride_out[i*ADDR_WIDTH +: ADDR_WIDTH];
            li_q   <= bus.cfg_len_in[i*CNT_WIDTH +: CNT_WIDTH];
            lo_q   <= bus.cfg_len_out[i*CNT_WIDTH +: CNT_WIDTH];
            icnt_q <= '0;
            ocnt_q <= '0;
            done_q <= 1'b0;
`ifdef AGU_WRAP_EN
            start_q <= bus.cfg_start[i*ADDR_WIDTH +: ADDR_WIDTH];
`endif
         end else begin
`ifdef AGU_WRAP_EN
            // done is a one-cycle pulse in circular mode
            done_q <= 1'b0;
`endif
            if (step) begin
               if (!inner_end) begin
                  icnt_q <= icnt_q + CNT_WIDTH'(1);
                  addr_q <= addr_q + si_q;
               end else if (!outer_end) begin
                  // next row starts from the advanced base, not from addr
                  icnt_q <= '0;
                  ocnt_q <= ocnt_q + CNT_WIDTH'(1);
                  base_q <= base_q + so_q;
                  addr_q <= base_q + so_q;
               end else begin
`ifdef AGU_WRAP_EN
                  addr_q <= start_q;
                  base_q <= start_q;
                  icnt_q <= '0;
                  ocnt_q <= '0;
`endif
                  done_q <= 1'b1;
               end
            end
         end
      end

      assign addr_ch[i] = addr_q;
      assign done_ch[i] = done_q;
   end

   always_comb begin
      bus.addr = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_ch[i];
      end
   end

   assign bus.row_last = row_last_ch;
   assign bus.done     = done_ch;

endmodule

// File: tb/tb_agu_2d.sv
// tb_agu_2d: scoreboard bench for agu_2d (default 14-bit, 4 channels).
// Stimulus pushes expected per-channel addr/row_last/done, tagged with the
// clock cycle they must appear in; a monitor pops and compares after each
// rising edge.
module tb_agu_2d;
   localparam int AW = 14;
   localparam int NC = 4;
   localparam int CW = 10;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   agu_2d_if #(.ADDR_WIDTH(AW), .NUM_CH(NC), .CNT_WIDTH(CW)) bus ();

   agu_2d #(.ADDR_WIDTH(AW), .NUM_CH(NC), .CNT_WIDTH(CW)) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct {
      int unsigned   tag;
      int unsigned   ch;
      logic [AW-1:0] addr;
      logic          rl;
      logic          dn;
      string         name;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;

   // tb-side copy of the configuration, used by the reference model
   logic [AW-1:0] c_start [NC];
   logic [AW-1:0] c_si    [NC];
   logic [AW-1:0] c_so    [NC];
   logic [CW-1:0] c_li    [NC];
   logic [CW-1:0] c_lo    [NC];

   // reference model state
   logic [AW-1:0] m_addr [NC];
   logic [AW-1:0] m_base [NC];
   logic [AW-1:0] m_start[NC];
   logic [AW-1:0] m_si   [NC];
   logic [AW-1:0] m_so   [NC];
   int unsigned   m_icnt [NC];
   int unsigned   m_ocnt [NC];
   int unsigned   m_li   [NC];
   int unsigned   m_lo   [NC];
   logic          m_done [NC];

   // monitor
   initial begin
      exp_t          e;
      logic [AW-1:0] a;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         while (sb.size() > 0 && sb[0].tag <= cyc) begin
            e = sb.pop_front();
            a = bus.addr[e.ch*AW +: AW];
            vectors++;
            if (a !== e.addr || bus.row_last[e.ch] !== e.rl || bus.done[e.ch] !== e.dn) begin
               miscompares++;
               $display("FAIL %s ch%0d cyc%0d: got addr=%h row_last=%b done=%b, want addr=%h row_last=%b done=%b",
                        e.name, e.ch, cyc, a, bus.row_last[e.ch], bus.done[e.ch], e.addr, e.rl, e.dn);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic [NC-1:0] clr, input logic [NC-1:0] add);
      @(negedge clk);
      bus.clr_en = clr;
      bus.add_en = add;
   endtask

   task automatic expect_ch(input int unsigned ch, input logic [AW-1:0] a,
                            input logic rl, input logic dn, input string nm);
      exp_t e;
      e.tag  = cyc + 1;
      e.ch   = ch;
      e.addr = a;
      e.rl   = rl;
      e.dn   = dn;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic set_cfg(input int unsigned ch, input logic [AW-1:0] st,
                          input logic [AW-1:0] si, input logic [AW-1:0] so,
                          input logic [CW-1:0] li, input logic [CW-1:0] lo);
      bus.cfg_start     [ch*AW +: AW] = st;
      bus.cfg_stride_in [ch*AW +: AW] = si;
      bus.cfg_stride_out[ch*AW +: AW] = so;
      bus.cfg_len_in    [ch*CW +: CW] = li;
      bus.cfg_len_out   [ch*CW +: CW] = lo;
      c_start[ch] = st;
      c_si[ch]    = si;
      c_so[ch]    = so;
      c_li[ch]    = li;
      c_lo[ch]    = lo;
   endtask

   // Reference: applies one cycle of strobes, then pushes every channel.
   task automatic model_cycle(input logic [NC-1:0] clr, input logic [NC-1:0] add);
      logic wrap;
`ifdef AGU_WRAP_EN
      wrap = 1'b1;
`else
      wrap = 1'b0;
`endif
      drive(clr, add);
      for (int c = 0; c < NC; c++) begin
         if (clr[c]) begin
            m_addr[c] = c_start[c];  m_base[c] = c_start[c];  m_start[c] = c_start[c];
            m_si[c] = c_si[c];  m_so[c] = c_so[c];
            m_li[c] = int'(c_li[c]);  m_lo[c] = int'(c_lo[c]);
            m_icnt[c] = 0;  m_ocnt[c] = 0;  m_done[c] = 1'b0;
         end else begin
            if (wrap) m_done[c] = 1'b0;
            if (add[c] && (wrap || !m_done[c])) begin
               if (m_icnt[c] < m_li[c]) begin
                  m_icnt[c]++;
                  m_addr[c] = AW'((int'(m_addr[c]) + int'(m_si[c])) % (1 << AW));
               end else if (m_ocnt[c] < m_lo[c]) begin
                  m_icnt[c] = 0;
                  m_ocnt[c]++;
                  m_base[c] = AW'((int'(m_base[c]) + int'(m_so[c])) % (1 << AW));
                  m_addr[c] = m_base[c];
               end else begin
                  if (wrap) begin
                     m_addr[c] = m_start[c];  m_base[c] = m_start[c];
                     m_icnt[c] = 0;  m_ocnt[c] = 0;
                  end
                  m_done[c] = 1'b1;
               end
            end
         end
         expect_ch(c, m_addr[c], (m_icnt[c] == m_li[c]) && (wrap || !m_done[c]),
                   m_done[c], "t4_multi");
      end
   endtask

   logic [AW-1:0] t2_a  [5] = '{14'h101, 14'h102, 14'h110, 14'h111, 14'h112};
   logic          t2_rl [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic [NC-1:0] t4_clr[16] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
   logic [NC-1:0] t4_add[16] = '{4'hF, 4'h5, 4'hA, 4'h3, 4'hC, 4'hF, 4'h9, 4'h6,
                                 4'hF, 4'hF, 4'hF, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF};

   initial begin
      int unsigned waited;
      bus.clr_en = '0;
      bus.add_en = '0;
      bus.cfg_start = '0;
      bus.cfg_stride_in = '0;
      bus.cfg_stride_out = '0;
      bus.cfg_len_in = '0;
      bus.cfg_len_out = '0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      // reset then idle
      for (int k = 0; k < 5; k++) begin
         drive('0, '0);
         for (int c = 0; c < NC; c++) expect_ch(c, '0, 1'b1, 1'b0, "t1_reset_idle");
      end

      // ch0 2-D walk; cfg is scrambled after the load and must be ignored
      set_cfg(0, 14'h100, 14'h1, 14'h10, 10'd2, 10'd1);
      drive(4'h1, 4'h0);
      expect_ch(0, 14'h100, 1'b0, 1'b0, "t2_load");
      for (int k = 0; k < 5; k++) begin
         drive(4'h0, 4'h1);
         if (k == 0) set_cfg(0, 14'h2AA, 14'h7, 14'h55, 10'd5, 10'd3);
         expect_ch(0, t2_a[k], t2_rl[k], 1'b0, "t2_walk");
      end
`ifdef AGU_WRAP_EN
      drive(4'h0, 4'h1); expect_ch(0, 14'h100, 1'b0, 1'b1, "t2_wrap_end");
      drive(4'h0, 4'h1); expect_ch(0, 14'h101, 1'b0, 1'b0, "t2_wrap_cont");
      drive(4'h0, 4'h1); expect_ch(0, 14'h102, 1'b1, 1'b0, "t2_wrap_cont");
      drive(4'h0, 4'h1); expect_ch(0, 14'h110, 1'b0, 1'b0, "t2_wrap_cont");
`else
      drive(4'h0, 4'h1); expect_ch(0, 14'h112, 1'b0, 1'b1, "t2_done");
      for (int k = 0; k < 3; k++) begin
         drive(4'h0, 4'h1); expect_ch(0, 14'h112, 1'b0, 1'b1, "t5_hold_after_done");
      end
`endif
      drive(4'h1, 4'h0); expect_ch(0, 14'h2AA, 1'b0, 1'b0, "t5_reclr");
      drive(4'h0, 4'h0); expect_ch(0, 14'h2AA, 1'b0, 1'b0, "t5_reclr_idle");

      // clr+add same cycle, then modulo wrap
      set_cfg(1, 14'h3FFF, 14'h2, 14'h0, 10'd3, 10'd0);
      drive(4'h2, 4'h2); expect_ch(1, 14'h3FFF, 1'b0, 1'b0, "t3_clr_prec");
      drive(4'h0, 4'h2); expect_ch(1, 14'h0001, 1'b0, 1'b0, "t3_mod_wrap");

      // zero lengths: first add ends the pattern
      set_cfg(2, 14'h55, 14'h9, 14'h9, 10'd0, 10'd0);
      drive(4'h4, 4'h0); expect_ch(2, 14'h55, 1'b1, 1'b0, "t3_len0_load");
`ifdef AGU_WRAP_EN
      drive(4'h0, 4'h4); expect_ch(2, 14'h55, 1'b1, 1'b1, "t3_len0_end");
      drive(4'h0, 4'h0); expect_ch(2, 14'h55, 1'b1, 1'b0, "t3_len0_pulse");
`else
      drive(4'h0, 4'h4); expect_ch(2, 14'h55, 1'b0, 1'b1, "t3_len0_end");
      drive(4'h0, 4'h0); expect_ch(2, 14'h55, 1'b0, 1'b1, "t3_len0_sticky");
`endif

      // negative inner stride, zero outer stride
      set_cfg(3, 14'h10, 14'h3FFF, 14'h0, 10'd1, 10'd1);
      drive(4'h8, 4'h0); expect_ch(3, 14'h10, 1'b0, 1'b0, "t3_neg_load");
      drive(4'h0, 4'h8); expect_ch(3, 14'h0F, 1'b1, 1'b0, "t3_neg_step");
      drive(4'h0, 4'h8); expect_ch(3, 14'h10, 1'b0, 1'b0, "t3_neg_row");
      drive(4'h0, 4'h8); expect_ch(3, 14'h0F, 1'b1, 1'b0, "t3_neg_step");
`ifdef AGU_WRAP_EN
      drive(4'h0, 4'h8); expect_ch(3, 14'h10, 1'b0, 1'b1, "t3_neg_end");
`else
      drive(4'h0, 4'h8); expect_ch(3, 14'h0F, 1'b0, 1'b1, "t3_neg_end");
`endif

`ifdef AGU_WRAP_EN
      // circular buffer
      set_cfg(0, 14'h20, 14'h4, 14'h0, 10'd1, 10'd0);
      drive(4'h1, 4'h0); expect_ch(0, 14'h20, 1'b0, 1'b0, "t6_load");
      drive(4'h0, 4'h1); expect_ch(0, 14'h24, 1'b1, 1'b0, "t6_circ");
      drive(4'h0, 4'h1); expect_ch(0, 14'h20, 1'b0, 1'b1, "t6_circ_done");
      drive(4'h0, 4'h1); expect_ch(0, 14'h24, 1'b1, 1'b0, "t6_circ");
      drive(4'h0, 4'h1); expect_ch(0, 14'h20, 1'b0, 1'b1, "t6_circ_done");
`endif

      // all channels concurrently against the reference model
      set_cfg(0, 14'h0000, 14'h0003, 14'h0040, 10'd1, 10'd2);
      set_cfg(1, 14'h1000, 14'h3FFE, 14'h0100, 10'd2, 10'd1);
      set_cfg(2, 14'h3FF0, 14'h0008, 14'h0020, 10'd0, 10'd3);
      set_cfg(3, 14'h0777, 14'h0000, 14'h0005, 10'd3, 10'd0);
      for (int k = 0; k < 16; k++) model_cycle(t4_clr[k], t4_add[k]);

      // reset asserted mid-pattern, not resumed afterwards
      set_cfg(0, 14'h0100, 14'h0001, 14'h0010, 10'd2, 10'd1);
      drive(4'h1, 4'h0);
      drive(4'h0, 4'h1);
      @(negedge clk);
      bus.add_en = '0;
      rstn = 1'b0;
      for (int c = 0; c < NC; c++) expect_ch(c, '0, 1'b1, 1'b0, "t7_reset_mid");
      @(negedge clk);
      rstn = 1'b1;
      for (int c = 0; c < NC; c++) expect_ch(c, '0, 1'b1, 1'b0, "t7_after_reset");
`ifdef AGU_WRAP_EN
      drive(4'h0, 4'h1); expect_ch(0, '0, 1'b1, 1'b1, "t7_no_resume");
`else
      drive(4'h0, 4'h1); expect_ch(0, '0, 1'b0, 1'b1, "t7_no_resume");
`endif
      drive('0, '0);

      waited = 0;
      while (sb.size() > 0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (sb.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/agu_2d.md
Name: agu_2d

Overview:
- Parametrised multi-channel address generation unit; successor to the four-channel start/increment/stride-by-2 generator.
- Each channel walks a 2-D pattern: inner loop with programmable inner stride, outer loop with programmable outer stride.
- Sits between the matrix-op controller FSM and the operand SRAM ports. The controller issues per-channel load (clr_en) and advance (add_en) strobes; the block returns addresses plus end-of-row and end-of-pattern status.

Parameters:
- ADDR_WIDTH, 14, full address width per channel (bank-select bits included).
- NUM_CH, 4, number of independent channels.
- CNT_WIDTH, 10, width of the inner and outer loop counters.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous reset, active-low.
- clr_en  input  NUM_CH  per-channel load strobe.
- add_en  input  NUM_CH  per-channel advance strobe.
- cfg_start  input  NUM_CH*ADDR_WIDTH  start address; channel i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- cfg_stride_in  input  NUM_CH*ADDR_WIDTH  inner-loop increment, same packing.
- cfg_stride_out  input  NUM_CH*ADDR_WIDTH  outer-loop increment, applied to the row base, same packing.
- cfg_len_in  input  NUM_CH*CNT_WIDTH  inner iterations minus 1.
- cfg_len_out  input  NUM_CH*CNT_WIDTH  outer iterations minus 1.
- addr  output  NUM_CH*ADDR_WIDTH  current address, registered.
- row_last  output  NUM_CH  channel's inner counter equals its latched len_in.
- done  output  NUM_CH  pattern complete.

Behaviour:
- Per-channel state: addr, row base, inner count icnt, outer count ocnt, latched stride_in/stride_out/len_in/len_out, done.
- Reset: all state 0; addr=0, done=0, row_last=1 (0==0 against latched lengths of 0).
- clr_en[i]:
  - addr and base load cfg_start; icnt=0, ocnt=0, done=0.
  - strides and lengths are latched from cfg_*.
  - The config buses are ignored at all other times.
- add_en[i], clr_en[i]=0, done[i]=0, one step per cycle; new addr is visible the cycle after the strobe:
  - icnt != len_in: icnt+1; addr = addr + stride_in.
  - icnt == len_in and ocnt != len_out: icnt=0; ocnt+1; base = base + stride_out; addr = base + stride_out (old base).
  - icnt == len_in and ocnt == len_out: end of pattern; see Optional Feature.
- Precedence: clr_en over add_en when both are high in the same cycle.
- add_en while done=1 and AGU_WRAP_EN is undefined: ignored; all state holds.
- Arithmetic: unsigned, modulo 2^ADDR_WIDTH; overflow wraps silently.
  - Negative strides are encoded as two's complement.
  - Stride 0 is legal: address holds while the counters advance.
- Lengths of 0 mean one iteration. With len_in=len_out=0, the first add_en ends the pattern.
- row_last: combinational from the registered counters. Asserted while icnt==len_in and done=0; forced 0 when done=1.
- Channels are fully independent; no shared state or arbitration.
- Reset asserted mid-pattern: immediate return to reset values; the pattern is not resumed after reset.

Optional Feature:
- Macro AGU_WRAP_EN.
- Undefined: at end of pattern, done=1 (sticky until the next clr_en); addr, icnt and ocnt hold.
- Defined: at end of pattern the channel auto-reloads.
  - addr and base take the latched start address (an extra start register per channel); icnt=0, ocnt=0.
  - done pulses high for exactly one cycle, then the channel keeps stepping on add_en (circular buffer mode).
  - row_last is not forced low.

Test Plan:
- Reset then idle: all addr=0, done=0, row_last=1 for 5 cycles with no strobes.
- Ch0 clr with start=0x100, stride_in=1, stride_out=0x10, len_in=2, len_out=1; 6 add_en -> addr 0x101, 0x102, 0x110, 0x111, 0x112, 0x112. done=1 after the 6th strobe; row_last high when addr is 0x102 and 0x112 (before done).
- Same cycle clr_en[1] and add_en[1] with start=0x3FFF -> addr=0x3FFF, counters 0. Next add_en with stride_in=2 -> addr=0x0001 (modulo wrap).
- All NUM_CH channels loaded with different starts and strided concurrently, with independent add_en patterns -> each channel matches its own reference model; no cross-channel interference.
- add_en held high after done (macro off) -> addr frozen and done stays 1 until clr_en, which clears done the next cycle.
- AGU_WRAP_EN defined, len_in=1, len_out=0, start=0x20, stride_in=4 -> addr sequence 0x24, 0x20, 0x24, 0x20. done pulses one cycle on each return to 0x20.
